// File: rtl/cla_share_sched_pkg.sv
// Shared definitions for the time-shared carry-lookahead adder scheduler.
package cla_share_sched_pkg;

    localparam int W    = 32;
    localparam int DW   = 64;
    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/cla_share_sched_if.sv
// Request/response bundle between the adder clients and the shared scheduler.
interface cla_share_sched_if #(
    parameter int NREQ = 4
);
    import cla_share_sched_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_wide;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [DW-1:0]      rsp_sum;
    logic               rsp_cout;

    modport master (
        output req_valid, req_wide, req_cin, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_wide, req_cin, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

endinterface

// File: rtl/cla32bit.sv
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
module cla32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        gp = '0;
        c[0] = cin;
        for (int grp = 0; grp < 8; grp++) begin
            gp[grp] = &p[grp*4 +: 4];
            gg[grp] = g[grp*4+3]
                    | (p[grp*4+3] & g[grp*4+2])
                    | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                    | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4]);
            for (int j = 0; j < 3; j++) begin
                c[grp*4+j+1] = g[grp*4+j] | (p[grp*4+j] & c[grp*4+j]);
            end
            c[grp*4+4] = gg[grp] | (gp[grp] & c[grp*4]);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end

endmodule

// File: rtl/cla_share_sched_rr_grant.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module rr_grant
    import cla_share_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && (((valid >> idx) & NREQ'(1)) != '0)) begin
                grant     = NREQ'(1) << idx;
                grant_idx = ID_W'(idx);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cla_share_sched.sv
// Shares one cla32bit between NREQ requesters; wide ops take a low and a high pass.
//
// state | meaning
// IDLE  | arbitrating; req_ready follows the round-robin grant
// LO    | adding low 32 bits with the requester's carry-in
// HI    | adding high 32 bits with the registered low-half carry
// RESP  | holding the result until rsp_ready
module cla_share_sched
    import cla_share_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    cla_share_sched_if.slave   bus,
    output logic               busy
);

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   a_reg;
    logic [DW-1:0]   b_reg;
    logic            wide_reg;
    logic            cin_reg;
    logic            carry_reg;
    logic [ID_W-1:0] id_reg;
    logic [ID_W-1:0] last_grant;
    logic [DW-1:0]   res;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic            sel_wide;
    logic            sel_cin;

    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic            add_cin;
    logic [W-1:0]    add_sum;
    logic            add_cout;

    rr_grant #(.NREQ(NREQ)) u_rr_grant (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    cla32bit u_cla32bit (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Gating with rst keeps req_ready low while reset is held, even with valids pending.
    assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = res;
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_cout  = carry_reg;
    assign busy          = (state != IDLE);

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_wide = 1'b0;
        sel_cin  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a    = bus.req_a[i*DW +: DW];
                sel_b    = bus.req_b[i*DW +: DW];
                sel_wide = bus.req_wide[i];
                sel_cin  = bus.req_cin[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Adder inputs rest at zero outside LO/HI so the shared datapath stays quiet.
    always_comb begin
        state_nxt = state;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LO;
                end
            end
            LO: begin
                add_a     = a_reg[W-1:0];
                add_b     = b_reg[W-1:0];
                add_cin   = cin_reg;
                state_nxt = wide_reg ? HI : RESP;
            end
            HI: begin
                add_a     = a_reg[DW-1:W];
                add_b     = b_reg[DW-1:W];
                add_cin   = carry_reg;
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            wide_reg   <= 1'b0;
            cin_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            id_reg     <= '0;
            last_grant <= ID_W'(NREQ - 1);
            res        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= sel_a;
                        b_reg      <= sel_b;
                        wide_reg   <= sel_wide;
                        cin_reg    <= sel_cin;
                        id_reg     <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                LO: begin
                    res       <= {{(DW-W){1'b0}}, add_sum};
                    carry_reg <= add_cout;
                end
                HI: begin
                    res[DW-1:W] <= add_sum;
                    carry_reg   <= add_cout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_share_sched.sv
// Table-driven and scenario checks for cla_share_sched with an in-order result scoreboard.
module tb_cla_share_sched;
    import cla_share_sched_pkg::*;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    cla_share_sched_if #(.NREQ(NREQ)) bus ();

    cla_share_sched #(.NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        wide;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [63:0] id;
        logic [63:0] sum;
        logic        cout;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   rsp_cnt = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic wide, input logic [63:0] a,
                         input logic [63:0] b, input logic cin);
        bus.req_wide[id]        = wide;
        bus.req_cin[id]         = cin;
        bus.req_a[id*64 +: 64]  = a;
        bus.req_b[id*64 +: 64]  = b;
        bus.req_valid[id]       = 1'b1;
    endtask

    task automatic push(input int id, input logic [63:0] sum, input logic cout, input logic wide);
        exp_t e;
        e.id   = 64'(id);
        e.sum  = sum;
        e.cout = cout;
        e.lat  = wide ? 3 : 2;
        sb.push_back(e);
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 40) begin
            tick();
            n++;
        end
        if (acc_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s: accept timeout, accepts=%0d expected=%0d", name, acc_cnt, target);
        end
    endtask

    task automatic wait_rsp(input int target, input string name);
        int n = 0;
        while (rsp_cnt < target && n < 60) begin
            tick();
            n++;
        end
        if (rsp_cnt < target) begin
            total++;
            bad++;
            $display("FAIL %s: response timeout, responses=%0d expected=%0d", name, rsp_cnt, target);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard side: pops on each completed response handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            chk("ready_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
            if (|(bus.req_valid & bus.req_ready)) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (bus.rsp_valid && !prev_valid && sb.size() > 0) begin
                chk("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got id %0d sum %h with nothing expected",
                             bus.rsp_id, bus.rsp_sum);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), e.id);
                    chk("rsp_sum", bus.rsp_sum, e.sum);
                    chk("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
                end
                rsp_cnt++;
            end
            prev_valid = bus.rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        int rtgt;

        vecs[0] = '{0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1,                  1'b0, 64'h0,                   1'b1};
        vecs[1] = '{2, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1,                  1'b0, 64'h0000_0001_0000_0000, 1'b0};
        vecs[2] = '{1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b1, 64'h0,                   1'b1};
        vecs[3] = '{3, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'h0000_0000_1111_1111, 1'b1, 64'h0000_0000_2345_678A, 1'b0};
        vecs[4] = '{0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0,                   1'b1};
        vecs[5] = '{1, 1'b1, 64'h0000_0001_7FFF_FFFF, 64'h0000_0002_8000_0001, 1'b0, 64'h0000_0004_0000_0000, 1'b0};
        vecs[6] = '{2, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b1};
        vecs[7] = '{3, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0};

        bus.req_valid = '0;
        bus.req_wide  = '0;
        bus.req_cin   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, including with every requester asking.
        rst = 1'b1;
        tick();
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_sum", bus.rsp_sum, 64'd0);
        chk("rst_rsp_cout", 64'(bus.rsp_cout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            tgt  = acc_cnt + 1;
            rtgt = rsp_cnt + 1;
            drive(vecs[i].id, vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].cin);
            push(vecs[i].id, vecs[i].sum, vecs[i].cout, vecs[i].wide);
            wait_acc(tgt, "vec_accept");
            bus.req_valid = '0;
            wait_rsp(rtgt, "vec_rsp");
        end

        // Round robin with all requesters held valid; last grant was requester 3.
        tgt  = acc_cnt + 6;
        rtgt = rsp_cnt + 6;
        for (int i = 0; i < NREQ; i++) begin
            drive(i, 1'b0, 64'(i * 256 + 5), 64'(i), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            push(k % NREQ, 64'((k % NREQ) * 257 + 5), 1'b0, 1'b0);
        end
        wait_acc(tgt, "rr_accept");
        bus.req_valid = '0;
        wait_rsp(rtgt, "rr_rsp");

        // Backpressure: result held while rsp_ready is low, with another requester waiting.
        bus.rsp_ready = 1'b0;
        tgt  = acc_cnt + 1;
        rtgt = rsp_cnt + 2;
        drive(1, 1'b0, 64'd7, 64'd8, 1'b0);
        push(1, 64'd15, 1'b0, 1'b0);
        wait_acc(tgt, "bp_accept");
        bus.req_valid = '0;
        drive(0, 1'b0, 64'd100, 64'd23, 1'b1);
        push(0, 64'd124, 1'b0, 1'b0);
        for (int n = 0; n < 10 && !bus.rsp_valid; n++) tick();
        for (int n = 0; n < 5; n++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_sum", bus.rsp_sum, 64'd15);
            chk("bp_id", 64'(bus.rsp_id), 64'd1);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tgt = acc_cnt + 1;
        tick();
        chk("bp_idle_busy", 64'(busy), 64'd0);
        chk("bp_idle_valid", 64'(bus.rsp_valid), 64'd0);
        chk("bp_idle_grant", 64'(bus.req_ready), 64'd1);
        wait_acc(tgt, "bp_accept2");
        bus.req_valid = '0;
        wait_rsp(rtgt, "bp_rsp");

        // Reset during the high pass of a wide op from requester 3.
        tgt = acc_cnt + 1;
        drive(3, 1'b1, 64'h0000_0002_FFFF_FFFF, 64'h0000_0003_0000_0001, 1'b0);
        push(3, 64'h0000_0006_0000_0000, 1'b0, 1'b1);
        wait_acc(tgt, "mid_accept");
        tick();
        chk("mid_busy", 64'(busy), 64'd1);
        drive(0, 1'b0, 64'h55, 64'h11, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("mid_rst_rsp_sum", bus.rsp_sum, 64'd0);
        chk("mid_rst_rsp_cout", 64'(bus.rsp_cout), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        push(0, 64'h66, 1'b0, 1'b0);
        push(3, 64'h0000_0006_0000_0000, 1'b0, 1'b1);
        tgt  = acc_cnt + 1;
        rtgt = rsp_cnt + 2;
        wait_acc(tgt, "post_rst_accept0");
        bus.req_valid[0] = 1'b0;
        wait_acc(tgt + 1, "post_rst_accept3");
        bus.req_valid = '0;
        wait_rsp(rtgt, "post_rst_rsp");

        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_share_sched.md
Name: cla_share_sched

Overview:
- Time-shares one cla32bit adder instance between NREQ requesters, using valid/ready handshakes and round-robin arbitration.
- Supports two operation widths:
  - 32-bit add: one adder pass.
  - 64-bit add: two sequential passes, low half first; the registered low-half carry is the high-half carry-in.
- Sits between multiplier/accumulator clients and the shared carry-lookahead datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, adder width. Fixed to 32 by cla32bit; wide ops are 2*W.

Ports:
- clk  in  1  clock, all state rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle.
- req_wide  in  NREQ  1 = 64-bit op, 0 = 32-bit op.
- req_a  in  NREQ*64  operand A, requester i at [64i+63:64i]; bits [63:32] ignored when narrow.
- req_b  in  NREQ*64  operand B, same packing.
- req_cin  in  NREQ  carry-in.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  3  index of the requester that owns the result.
- rsp_sum  out  64  sum; [63:32] = 0 for narrow ops.
- rsp_cout  out  1  carry-out of the final pass.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy all go to 0.
  - Round-robin pointer is set so requester 0 has highest priority.
  - Any in-flight op is discarded.
- States: IDLE -> LO -> (HI if wide) -> RESP -> IDLE.
- IDLE:
  - Grant goes to the first valid requester starting from (last_grant+1) mod NREQ, wrapping around.
  - req_ready[grant] is asserted combinationally in the same cycle.
  - Accept means req_valid[i] & req_ready[i]. On accept, register operands, wide, cin and id; update last_grant to i; go to LO.
  - The pointer changes only on accept.
  - With no valid requesters, stay in IDLE with req_ready = 0.
- LO:
  - Adder inputs are a_reg[31:0], b_reg[31:0], cin_reg.
  - Register sum into res[31:0] and cout into carry_reg.
  - Go to HI if wide, else go to RESP.
- HI:
  - Adder inputs are a_reg[63:32], b_reg[63:32], carry_reg.
  - Register sum into res[63:32] and cout into carry_reg.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_sum, rsp_cout and rsp_id are driven from registers.
  - All response outputs stay stable while rsp_ready = 0.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: rsp_valid rises 2 cycles after accept for narrow ops and 3 cycles after accept for wide ops.
- Throughput: one op per 3 cycles narrow, 4 cycles wide. Accepts never overlap responses; req_ready is low in all states except IDLE.
- Adder inputs are driven to 0 in IDLE and RESP so the adder does not toggle.
- Requesters must hold valid and operands until accepted. Dropping valid before accept is legal: that requester is simply not granted.
- Carry arithmetic is modulo 2^64. A wide overflow is reported only via rsp_cout.
- Reset asserted in any state, including mid-HI or mid-RESP, aborts the op with no response emitted.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, LO=2'd1, HI=2'd2, RESP=2'd3.
  - widths W=32 and DW=64.
  - id width.
- One sub-module: rr_grant (NREQ-wide round-robin picker).
  - Inputs: valid vector and last_grant.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- cla32bit is instantiated once inside cla_share_sched, unmodified.

Test Plan:
- Narrow: req0 a=0xFFFF_FFFF, b=1, cin=0 -> rsp_sum=0x0, rsp_cout=1, rsp_id=0; rsp_valid 2 cycles after accept.
- Wide: req2 a=0x0000_0000_FFFF_FFFF, b=1, cin=0 -> rsp_sum=0x0000_0001_0000_0000, rsp_cout=0, rsp_id=2; rsp_valid 3 cycles after accept.
- Wide carry: req1 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> rsp_sum=0, rsp_cout=1.
- Round-robin: all 4 req_valid held high with rsp_ready=1 -> accept order 0,1,2,3,0,1; never two req_ready bits high.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_sum, rsp_id constant; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Reset mid-op: assert rst during HI of a wide op from req3 -> all outputs 0 immediately. After release with req0 and req3 both valid, req0 is granted first and no stale response appears.
